paula_audio_dma_sched: RTL
==========================

PAULA_AUDIO_DMA_SCHED -- requirements
Module: paula_audio_dma_sched

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  bus clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- clk7_en  in  1  clock enable; no state change when low, reset excepted.
- cck  in  1  colour clock enable, qualified by clk7_en.
- hpos  in  9  horizontal beam position in colour clocks.
- strhor  in  1  horizontal strobe (line start).
- dmaen  in  1  master DMA enable.
- aud_en  in  4  per-channel audio DMA enable.
- dmareq  in  4  per-channel DMA request from the audio channels.
- dmas  in  4  per-channel pointer-restart request.
- reg_address_in  in  8  register address [8:1].
- data_in  in  16  register write data.
- dma  out  1  audio DMA bus cycle active.
- address_out  out  20  chip address [20:1].
- reg_address_out  out  8  destination register [8:1].
- dma_ack  out  4  per-channel one-enable pulse when a slot is serviced.

Function
REQ-002 SHALL hold per channel n (0..3): 20-bit location register loc[n] and 20-bit pointer ptr[n].
REQ-003 SHALL write loc[n][20:16] from data_in[4:0] on a write to reg_address_in == 8'h50+8*n (AUDnLCH), when clk7_en is high.
REQ-004 SHALL write loc[n][15:1] from data_in[15:1] on a write to reg_address_in == 8'h51+8*n (AUDnLCL), when clk7_en is high.
REQ-005 SHALL, on strhor with clk7_en, latch pend[n] <= dmareq[n] & aud_en[n] & dmaen and rst[n] <= dmas[n] for all n.
REQ-006 SHALL define slot n as hpos == 9'h00E + 2*n with cck and clk7_en high.
REQ-007 SHALL, in slot n with pend[n]=1 and aud_en[n]&dmaen=1:
- assert dma;
- address_out = rst[n] ? loc[n] : ptr[n];
- reg_address_out = 8'h55+8*n (AUDnDAT);
- pulse dma_ack[n] for that enable cycle;
- ptr[n] <= address_out + 1, 20-bit wrap (0xFFFFF -> 0x00000);
- clear pend[n] and rst[n].
REQ-008 SHALL, in slot n with pend[n]=1 but aud_en[n]&dmaen=0, clear pend[n] and rst[n] without dma or ack; ptr[n] unchanged.
REQ-009 SHALL drive dma=0, address_out=0, reg_address_out=8'hFF, dma_ack=0 in all non-serviced cycles; all outputs are combinational from registered state and current slot.
REQ-010 SHALL implement FSM (state changes only with clk7_en):
- IDLE: pend==0; strhor with any latched request -> ARMED.
- ARMED: slots serviced; after slot 3 (hpos 9'h014 with cck) -> DONE.
- DONE: no service; strhor -> ARMED if any latched request, else IDLE.
REQ-011 SHALL give strhor priority when it coincides with a slot: pend/rst are reloaded from the inputs, the old pending entry is dropped, and no dma is issued that cycle.
REQ-012 SHALL, when an LC write coincides with a restart slot of the same channel, use the old loc for address_out, then update loc.
REQ-013 SHALL service at most one channel per colour clock and at most one fetch per channel per line.
REQ-014 SHALL, on a dmaen drop while ARMED, suppress all remaining slots of the line per REQ-008.

Reset
REQ-015 SHALL, when reset_n is low, asynchronously clear loc, ptr, pend and rst, and set the FSM to IDLE; outputs then show dma=0, address_out=0, reg_address_out=8'hFF, dma_ack=0.
REQ-016 SHALL treat reset mid-line as dropping all pending requests; no dma occurs until the next strhor after reset_n rises.

Verification
REQ-017 Scenario: loc[0]=0x12340; dmareq=4'b0001 and dmas=4'b0001 at strhor; hpos=0x0E -> dma=1, address_out=0x12340, reg_address_out=8'h55, dma_ack=4'b0001; ptr[0]=0x12341.
REQ-018 Scenario: next line, dmareq[0]=1, dmas[0]=0 -> address_out=0x12341 at hpos 0x0E; ptr[0]=0x12342.
REQ-019 Scenario: all four channels request at strhor -> dma in slots 0x0E, 0x10, 0x12, 0x14 with reg_address_out 8'h55, 5D, 65, 6D; FSM reaches DONE.
REQ-020 Scenario: ptr[2]=0xFFFFF, dmas[2]=0 -> address_out=0xFFFFF; ptr[2]=0x00000.
REQ-021 Scenario: aud_en[1] cleared after strhor -> no dma at hpos 0x10; pend[1] cleared.
REQ-022 Scenario: reset_n low at hpos 0x0F with pend=4'b1110 -> outputs at reset values immediately; no dma at 0x10-0x14.

Source files
------------

// File: rtl/paula_audio_dma_sched.sv
// paula_audio_dma_sched: per-line audio DMA slot scheduler for four channels
module paula_audio_dma_sched (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk7_en,
    input  logic        cck,
    input  logic [8:0]  hpos,
    input  logic        strhor,
    input  logic        dmaen,
    input  logic [3:0]  aud_en,
    input  logic [3:0]  dmareq,
    input  logic [3:0]  dmas,
    input  logic [7:0]  reg_address_in,
    input  logic [15:0] data_in,
    output logic        dma,
    output logic [19:0] address_out,
    output logic [7:0]  reg_address_out,
    output logic [3:0]  dma_ack
);
    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
    state_t state, state_nx;
    logic [19:0] loc [4];
    logic [19:0] ptr [4];
    logic [3:0]  pend, rst, new_pend;
    logic [1:0]  ch;
    logic        slot_hit, svc, unused_bit;
    assign unused_bit = data_in[0];
    always_comb begin
        ch       = hpos[2:1] + 2'd1;
        new_pend = dmareq & aud_en & {4{dmaen}};
        slot_hit = clk7_en & cck & ~strhor & ~hpos[0] & (hpos >= 9'h00E) & (hpos <= 9'h014);
        svc      = slot_hit & (state == ARMED) & pend[ch] & aud_en[ch] & dmaen;
        dma             = svc;
        dma_ack         = svc ? 4'b0001 << ch : 4'b0000;
        address_out     = svc ? (rst[ch] ? loc[ch] : ptr[ch]) : 20'h0;
        reg_address_out = svc ? 8'h55 + {3'b000, ch, 3'b000} : 8'hFF;
        state_nx = state;
        if (clk7_en && strhor)
            state_nx = |new_pend ? ARMED : IDLE;
        else if (state == ARMED && slot_hit && hpos == 9'h014)
            state_nx = DONE;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            pend <= 4'b0;
            rst  <= 4'b0;
            for (int i = 0; i < 4; i++) begin
                loc[i] <= 20'h0;
                ptr[i] <= 20'h0;
            end
        end else if (clk7_en) begin
            // loc holds chip address bits [20:1]; LCH carries the top five
            for (int i = 0; i < 4; i++) begin
                if (reg_address_in == 8'(8'h50 + 8 * i))
                    loc[i][19:15] <= data_in[4:0];
                if (reg_address_in == 8'(8'h51 + 8 * i))
                    loc[i][14:0] <= data_in[15:1];
            end
            if (strhor) begin
                pend <= new_pend;
                rst  <= dmas;
            end else if (slot_hit) begin
                pend[ch] <= 1'b0;
                rst[ch]  <= 1'b0;
                if (svc)
                    ptr[ch] <= address_out + 20'd1;
            end
        end
endmodule
